muldiv_unit: RTL
================

# muldiv_unit

Multi-cycle RV32M execution unit that replaces the single-cycle combinational multiply/divide/remainder path in the CPU datapath. It is parametrised in operand width and uses iterative shift-add multiplication and restoring division. The datapath stalls on `busy` and writes `result` to rd on `done`. All RISC-V M-extension corner cases (divide-by-zero, signed overflow) are resolved in hardware with a one-cycle fast path.

## Interface
- `XLEN`, 32, operand/result width; must be ≥ 4 and even.
- `CNT_W`, $clog2(XLEN)+1, iteration counter width.

- `clk`  in  1  rising-edge clock.
- `SYS_reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only when `busy`=0.
- `funct3`  in  3  M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op_a`  in  XLEN  rs1 value.
- `op_b`  in  XLEN  rs2 value.
- `kill`  in  1  synchronous abort of the in-flight op (terminate/flush).
- `busy`  out  1  high from the edge that accepts `start` until the edge before `done`.
- `done`  out  1  one-cycle pulse; `result` is valid in that cycle.
- `result`  out  XLEN  registered result; holds until the next accepted `start`.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - On `start`, latch `funct3` and the operand magnitudes (absolute value when the op treats that operand as signed and it is negative).
  - Record the result sign:
    - MUL/MULH: sign(a) XOR sign(b).
    - MULHSU: sign(a).
    - DIV: sign(a) XOR sign(b).
    - REM: sign(a).
  - Clear the accumulator and set counter = XLEN, then go to CALC.
- Fast path from IDLE (goes directly to DONE, skipping CALC/FIX):
  - DIV/DIVU with b=0: quotient = all ones.
  - REM/REMU with b=0: remainder = a.
  - DIV with a=most-negative and b=−1: quotient = a.
  - REM with a=most-negative and b=−1: remainder = 0.
- CALC, one bit per cycle, counter decrements:
  - Multiply: 2·XLEN-bit product register; add the multiplicand when the LSB of the multiplier is 1, then shift right.
  - Divide: restoring algorithm; shift {rem, quo} left, trial-subtract the divisor, set the quotient bit when the difference is non-negative.
  - Leave CALC when the counter reaches 0.
- FIX:
  - Apply two's-complement negation (full 2·XLEN width for multiply) when the recorded sign is 1.
  - Select the result field:
    - MUL: low XLEN bits.
    - MULH/MULHSU/MULHU: high XLEN bits.
    - DIV/DIVU: quotient.
    - REM/REMU: remainder.
  - Load `result`.
- DONE: assert `done` for one cycle, then return to IDLE.
- `start` while `busy`=1 is ignored.
- `kill` in any state other than IDLE:
  - Next edge goes to IDLE; `done` is not asserted.
  - `result` keeps its previous value.
- `kill` and `start` in the same IDLE cycle: `start` is ignored.
- Arithmetic:
  - All intermediate values are unsigned magnitudes.
  - The remainder register is XLEN+1 bits so the trial subtract never overflows.
  - All wrap-around is modulo 2^XLEN on `result`.

## Timing
- Reset values (asynchronous, effective immediately): state IDLE, `busy`=0, `done`=0, `result`=0, counter=0.
- `SYS_reset` mid-operation discards the op; no `done` is produced.
- Normal op: `start` sampled at edge E0.
  - CALC occupies edges E1..E_XLEN.
  - FIX occurs at edge E_XLEN+1.
  - `done` is high during the cycle after edge E_XLEN+1, i.e. XLEN+2 cycles after E0 (34 cycles at XLEN=32).
- Fast path: `done` is high in the cycle immediately after E0 (latency 1).
- `busy`:
  - Goes high after E0 for normal ops and is low again in the `done` cycle.
  - Stays 0 for fast-path ops.
- Back-to-back: a new `start` is accepted in the `done` cycle, so no bubble beyond `done` is required.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - MUL/MULH/MULHSU/MULHU compute the full 2·XLEN product with a single combinational multiplier in IDLE, including sign handling.
  - The product is registered and the op goes directly to DONE (latency 1, `busy` stays 0).
  - Division is unchanged.
- `MULDIV_FAST_MUL_EN` undefined:
  - All multiplies use the iterative CALC path with XLEN+2 latency.
  - No XLEN×XLEN multiplier is synthesised.

## Test plan
- MUL, a=7, b=0xFFFFFFFD (−3) -> `result`=0xFFFFFFEB; `done` 34 cycles after `start` (1 cycle with `MULDIV_FAST_MUL_EN`).
- DIV, a=0x80000000, b=0xFFFFFFFF -> 0x80000000 in 1 cycle; REM with the same operands -> 0x00000000 in 1 cycle; `busy` never high.
- DIVU, a=100, b=0 -> 0xFFFFFFFF; REMU, a=100, b=0 -> 0x00000064; both with 1-cycle latency.
- MULHU, a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULHSU, a=b=0xFFFFFFFF -> 0xFFFFFFFF; MULH, a=b=0xFFFFFFFF -> 0x00000000.
- DIV, a=0xFFFFFFF9 (−7), b=2 -> 0xFFFFFFFD (−3); REM with the same operands -> 0xFFFFFFFF (−1); DIVU, a=0xFFFFFFF9, b=2 -> 0x7FFFFFFC.
- DIV started, `kill` at cycle 10 -> no `done`, `busy`=0 next cycle, `result` unchanged.
  - A new `start` is then accepted and completes normally.
  - `SYS_reset` asserted mid-CALC -> `busy`/`done`/`result` are 0 without waiting for a clock edge.

Source files
------------

// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between the CPU datapath and muldiv_unit.
//   start, funct3, op_a, op_b, kill : datapath -> unit (request side)
//   busy, done, result              : unit -> datapath (response side)
// Modports: master (datapath), slave (muldiv_unit).
interface muldiv_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            kill;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, funct3, op_a, op_b, kill,
        input  busy, done, result
    );

    modport slave (
        input  start, funct3, op_a, op_b, kill,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV32M multiply / divide / remainder unit.
// Iterative shift-add multiplication and restoring division on unsigned
// magnitudes, with sign fix-up after the loop. Divide-by-zero and signed
// overflow resolve in a single cycle without entering the loop.
//
// Ports:
//   clk        rising-edge clock
//   SYS_reset  asynchronous, active-high reset
//   bus        muldiv_if.slave: start/funct3/op_a/op_b/kill in,
//              busy/done/result out (all outputs registered)
//
// Build option:
//   MULDIV_FAST_MUL_EN  when defined, multiplies use one combinational
//                       XLEN x XLEN multiplier and complete in one cycle;
//                       division is unaffected.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start; fast-path ops complete straight to DONE
// CALC  | one multiply/divide bit per cycle, counter counts XLEN down to 0
// FIX   | sign correction, field select, load result
// DONE  | done pulse; a new start is accepted here as in IDLE
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input logic     clk,
    input logic     SYS_reset,
    muldiv_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t            r_state;
    logic [2:0]        r_op;
    logic              r_sign;
    logic [CNT_W-1:0]  r_cnt;
    logic [2*XLEN-1:0] r_prod;
    logic [XLEN-1:0]   r_mcand;
    logic [XLEN:0]     r_rem;
    logic [XLEN-1:0]   r_quo;
    logic [XLEN-1:0]   r_div;
    logic              r_busy;
    logic              r_done;
    logic [XLEN-1:0]   r_result;

    // ---------------- request decode ----------------
    logic [2:0]      w_f3;
    logic            w_a_signed;
    logic            w_b_signed;
    logic            w_sa;
    logic            w_sb;
    logic            w_sign;
    logic [XLEN-1:0] w_mag_a;
    logic [XLEN-1:0] w_mag_b;
    logic            w_b_zero;
    logic            w_ovf;
    logic            w_fast;
    logic [XLEN-1:0] w_fast_res;
    logic            w_accept;

    assign w_f3       = bus.funct3;
    // Divide ops: even funct3 is signed. Multiply ops: a is signed except
    // MULHU, b is signed only for MUL/MULH.
    assign w_a_signed = w_f3[2] ? ~w_f3[0] : (w_f3[1:0] != 2'b11);
    assign w_b_signed = w_f3[2] ? ~w_f3[0] : ~w_f3[1];
    assign w_sa       = w_a_signed & bus.op_a[XLEN-1];
    assign w_sb       = w_b_signed & bus.op_b[XLEN-1];
    // REM takes the dividend's sign; every other signed op XORs the
    // operand signs (unsigned operands are already masked to 0).
    assign w_sign     = (w_f3 == 3'b110) ? w_sa : (w_sa ^ w_sb);
    assign w_mag_a    = w_sa ? (-bus.op_a) : bus.op_a;
    assign w_mag_b    = w_sb ? (-bus.op_b) : bus.op_b;

    assign w_b_zero   = (bus.op_b == '0);
    assign w_ovf      = (bus.op_a == MOST_NEG) && (bus.op_b == {XLEN{1'b1}});
    assign w_fast     = w_f3[2] & (w_b_zero | (w_ovf & ~w_f3[0]));

    always_comb begin
        w_fast_res = '0;
        if (w_b_zero)
            w_fast_res = w_f3[1] ? bus.op_a : {XLEN{1'b1}};
        else
            w_fast_res = w_f3[1] ? '0 : bus.op_a;
    end

    // DONE accepts like IDLE so back-to-back ops need no bubble.
    assign w_accept = bus.start & ~bus.kill &
                      ((r_state == S_IDLE) || (r_state == S_DONE));

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] w_fm_prod;
    logic [2*XLEN-1:0] w_fm_full;
    logic [XLEN-1:0]   w_fm_res;

    assign w_fm_prod = {{XLEN{1'b0}}, w_mag_a} * {{XLEN{1'b0}}, w_mag_b};
    assign w_fm_full = w_sign ? (-w_fm_prod) : w_fm_prod;
    assign w_fm_res  = (w_f3[1:0] == 2'b00) ? w_fm_full[XLEN-1:0]
                                            : w_fm_full[2*XLEN-1:XLEN];
`endif

    // ---------------- iteration datapath ----------------
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_mul_next;
    logic [XLEN+1:0]   w_rem_sh;
    logic [XLEN+1:0]   w_rem_diff;
    logic              w_rem_ge;

    // Upper half accumulates, lower half holds the multiplier bits that
    // shift out; the carry out of the add becomes the new top bit.
    assign w_mul_sum  = {1'b0, r_prod[2*XLEN-1:XLEN]} +
                        (r_prod[0] ? {1'b0, r_mcand} : '0);
    assign w_mul_next = {w_mul_sum, r_prod[XLEN-1:1]};

    // Partial remainder stays below the divisor, so one guard bit above
    // the XLEN+1 remainder is enough to read the trial-subtract borrow.
    assign w_rem_sh   = {r_rem, r_quo[XLEN-1]};
    assign w_rem_diff = w_rem_sh - {2'b00, r_div};
    assign w_rem_ge   = ~w_rem_diff[XLEN+1];

    // ---------------- sign fix-up and field select ----------------
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_quo_fix;
    logic [XLEN-1:0]   w_rem_fix;
    logic [XLEN-1:0]   w_fix_res;

    assign w_prod_fix = r_sign ? (-r_prod) : r_prod;
    assign w_quo_fix  = r_sign ? (-r_quo) : r_quo;
    assign w_rem_fix  = r_sign ? (-r_rem[XLEN-1:0]) : r_rem[XLEN-1:0];

    always_comb begin
        w_fix_res = '0;
        case (r_op)
            3'b000:                 w_fix_res = w_prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_fix_res = w_prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_fix_res = w_quo_fix;
            default:                w_fix_res = w_rem_fix;
        endcase
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_sign   <= 1'b0;
            r_cnt    <= '0;
            r_prod   <= '0;
            r_mcand  <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_state <= S_IDLE;
                    if (w_accept) begin
                        r_op   <= w_f3;
                        r_sign <= w_sign;
                        if (w_fast) begin
                            r_result <= w_fast_res;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end
`ifdef MULDIV_FAST_MUL_EN
                        else if (!w_f3[2]) begin
                            r_result <= w_fm_res;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end
`endif
                        else begin
                            r_busy  <= 1'b1;
                            r_cnt   <= CNT_W'(XLEN);
                            r_prod  <= {{XLEN{1'b0}}, w_mag_b};
                            r_mcand <= w_mag_a;
                            r_rem   <= '0;
                            r_quo   <= w_mag_a;
                            r_div   <= w_mag_b;
                            r_state <= S_CALC;
                        end
                    end
                end

                S_CALC: begin
                    if (bus.kill) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        if (r_op[2]) begin
                            r_rem <= w_rem_ge ? w_rem_diff[XLEN:0] : w_rem_sh[XLEN:0];
                            r_quo <= {r_quo[XLEN-2:0], w_rem_ge};
                        end else begin
                            r_prod <= w_mul_next;
                        end
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == CNT_W'(1))
                            r_state <= S_FIX;
                    end
                end

                S_FIX: begin
                    r_busy <= 1'b0;
                    if (bus.kill) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_result <= w_fix_res;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;

endmodule
